// File: rtl/ltl_report_collector.sv
// Report collector for the LTL automata: tags non-zero report vectors with a symbol-index
// timestamp, buffers them in a FIFO, and counts overflow drops. Optional macro: LTL_REPORT_DEDUP_EN.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int DEPTH       = 8,
  parameter int TS_W        = 32,
  parameter int DROP_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic [7:0]               symbols,
  input  logic [NUM_REPORTS-1:0]   report_vec,
  input  logic                     clear_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [NUM_REPORTS-1:0]   out_report,
  output logic [7:0]               out_symbol,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  logic [TS_W-1:0]        ts_cnt;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [TS_W-1:0]        ts_mem  [DEPTH];
  logic [NUM_REPORTS-1:0] rep_mem [DEPTH];
  logic [7:0]             sym_mem [DEPTH];

  logic cand_p0;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Capture stage: decide whether this cycle's report vector becomes an entry
`ifdef LTL_REPORT_DEDUP_EN
  logic [NUM_REPORTS-1:0] last_vec;

  always_ff @(posedge clk) begin
    if (!reset_n)
      last_vec <= '0;
    else if (run)
      last_vec <= report_vec;
  end

  assign cand_p0 = run && (|report_vec) && (report_vec != last_vec);
`else
  assign cand_p0 = run && (|report_vec);
`endif

  assign full      = (fifo_level == LW'(DEPTH));
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign push      = cand_p0 && (!full || pop);
  assign drop      = cand_p0 && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_cnt     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (run)
        ts_cnt <= ts_cnt + TS_W'(1);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Overflow bookkeeping; a drop coinciding with clear wins as the first new drop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Storage stage: entry payload is data only and carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[wr_ptr]  <= ts_cnt;
      rep_mem[wr_ptr] <= report_vec;
      sym_mem[wr_ptr] <= symbols;
    end
  end

  assign out_ts     = out_valid ? ts_mem[rd_ptr]  : '0;
  assign out_report = out_valid ? rep_mem[rd_ptr] : '0;
  assign out_symbol = out_valid ? sym_mem[rd_ptr] : '0;

endmodule
